// File: rtl/lcd_text_buffer.sv
// 2xCOLS character frame buffer with a periodic refresh sequencer that streams
// changed frames to the HD44780 bus driver over a valid/ready byte interface.
module lcd_text_buffer #(
    parameter int unsigned COLS           = 16,
    parameter int unsigned REFRESH_CYCLES = 500000,
    localparam int unsigned AW            = $clog2(2 * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic          clear,
    output logic          out_valid,
    output logic          out_rs,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          frame_done,
    output logic          busy
);

    localparam int unsigned CELLS = 2 * COLS;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned TW    = $clog2(REFRESH_CYCLES);
    localparam logic [7:0]  SPACE    = 8'h20;
    localparam logic [7:0]  CMD_ROW0 = 8'h80;
    localparam logic [7:0]  CMD_ROW1 = 8'hC0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD0,
        S_ROW0,
        S_CMD1,
        S_ROW1
    } state_t;

    logic [7:0]    r_buf [CELLS];
    logic          r_dirty;
    logic [TW-1:0] r_cnt;
    state_t        r_state;
    logic [CW-1:0] r_col;
    logic          r_valid;
    logic          r_rs;
    logic [7:0]    r_data;
    logic          r_done;
    logic          r_busy;

    logic          w_tick;
    logic          w_wr_ok;
    logic          w_start;
    logic          w_xfer;
    logic          w_last_col;
    logic [CW-1:0] w_next_col;
    logic [AW-1:0] w_rd_row0;
    logic [AW-1:0] w_rd_row1;

    assign w_tick     = (r_cnt == TW'(REFRESH_CYCLES - 1));
    assign w_wr_ok    = wr_en && (32'(wr_addr) < CELLS);
    assign w_start    = (r_state == S_IDLE) && w_tick && r_dirty;
    assign w_xfer     = r_valid && out_ready;
    assign w_last_col = (r_col == CW'(COLS - 1));
    assign w_next_col = r_col + CW'(1);
    // Buffer addresses of the character following the one on the bus
    assign w_rd_row0  = AW'(w_next_col);
    assign w_rd_row1  = AW'(COLS) + AW'(w_next_col);

    assign out_valid  = r_valid;
    assign out_rs     = r_rs;
    assign out_data   = r_data;
    assign frame_done = r_done;
    assign busy       = r_busy;

    // Free-running refresh tick counter
    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    // Character storage: clear first so a simultaneous write lands on top
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CELLS); i++) begin
                r_buf[i] <= SPACE;
            end
        end else begin
            if (clear) begin
                for (int i = 0; i < int'(CELLS); i++) begin
                    r_buf[i] <= SPACE;
                end
            end
            if (w_wr_ok) begin
                r_buf[wr_addr] <= wr_char;
            end
        end
    end

    // A change in the frame-start cycle must survive into the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dirty <= 1'b1;
        end else if (w_wr_ok || clear) begin
            r_dirty <= 1'b1;
        end else if (w_start) begin
            r_dirty <= 1'b0;
        end
    end

    // Refresh sequencer; bus bytes are loaded on state entry and on each transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_valid <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_CMD0;
                        r_valid <= 1'b1;
                        r_rs    <= 1'b0;
                        r_data  <= CMD_ROW0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CMD0: begin
                    if (w_xfer) begin
                        r_state <= S_ROW0;
                        r_col   <= '0;
                        r_rs    <= 1'b1;
                        r_data  <= r_buf[0];
                    end
                end
                S_ROW0: begin
                    if (w_xfer) begin
                        if (w_last_col) begin
                            r_state <= S_CMD1;
                            r_rs    <= 1'b0;
                            r_data  <= CMD_ROW1;
                        end else begin
                            r_col  <= w_next_col;
                            r_data <= r_buf[w_rd_row0];
                        end
                    end
                end
                S_CMD1: begin
                    if (w_xfer) begin
                        r_state <= S_ROW1;
                        r_col   <= '0;
                        r_rs    <= 1'b1;
                        r_data  <= r_buf[AW'(COLS)];
                    end
                end
                S_ROW1: begin
                    if (w_xfer) begin
                        if (w_last_col) begin
                            r_state <= S_IDLE;
                            r_col   <= '0;
                            r_valid <= 1'b0;
                            r_rs    <= 1'b0;
                            r_data  <= 8'h00;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_col  <= w_next_col;
                            r_data <= r_buf[w_rd_row1];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Scoreboard bench for lcd_text_buffer: a shadow character buffer predicts each frame's byte
// stream, and a negedge monitor pops and compares every accepted byte.
module tb_lcd_text_buffer;

    localparam int unsigned COLS = 16;
    localparam int unsigned RC   = 8;
    localparam int unsigned AW   = 5;
    localparam int unsigned NB   = 2 * COLS + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_char;
    logic          clear;
    logic          out_valid;
    logic          out_rs;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          frame_done;
    logic          busy;

    lcd_text_buffer #(.COLS(COLS), .REFRESH_CYCLES(RC)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_rs     (out_rs),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         n_vec    = 0;
    int         n_fail   = 0;
    int         n_done   = 0;
    int         byte_cnt = 0;
    int         tcnt     = 0;
    logic [8:0] exp_q [$];
    logic [7:0] mbuf [2*COLS];
    logic       stall_pending = 1'b0;
    logic [8:0] held;

    // Reference refresh counter, used only to place multi-cycle writes between ticks
    always @(posedge clk) begin
        if (rst === 1'b1 || tcnt == int'(RC) - 1) tcnt <= 0;
        else tcnt <= tcnt + 1;
    end

    // Byte monitor: a transfer happens at the coming edge when valid & ready & !rst now
    always @(negedge clk) begin
        logic [8:0] e;
        if (stall_pending) begin
            n_vec++;
            if (out_valid !== 1'b1 || {out_rs, out_data} !== held) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%b rs/data=%h, required valid=1 rs/data=%h",
                         out_valid, {out_rs, out_data}, held);
            end
        end
        stall_pending = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0);
        held = {out_rs, out_data};
        if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got rs/data=%h, required no transfer", {out_rs, out_data});
            end else begin
                e = exp_q.pop_front();
                if ({out_rs, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL byte_%0d: got rs/data=%h, required %h", byte_cnt, {out_rs, out_data}, e);
                end
            end
            byte_cnt++;
        end
        if (frame_done === 1'b1) n_done++;
    end

    task automatic model_clear();
        for (int i = 0; i < int'(2 * COLS); i++) mbuf[i] = 8'h20;
    endtask

    task automatic push_frame();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < int'(COLS); i++) exp_q.push_back({1'b1, mbuf[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < int'(COLS); i++) exp_q.push_back({1'b1, mbuf[COLS + i]});
    endtask

    // One-cycle write (optionally with clear); called just after a rising edge
    task automatic wr(input int a, input logic [7:0] c, input logic clr);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_char = c;
        clear   = clr;
        @(posedge clk); #1;
        wr_en = 1'b0;
        clear = 1'b0;
        if (clr) model_clear();
        mbuf[a] = c;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int start = n_done;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (n_done > start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (byte_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic align_tick();
        for (int i = 0; i < int'(2 * RC); i++) begin
            if (tcnt == 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int  n;
        int  d0;
        bit  ok;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_char = 8'h00; clear = 1'b0; out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_vec++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", frame_done); end
        n_vec++;
        if ({out_rs, out_data} !== 9'h000) begin
            n_fail++; $display("FAIL rst_data: got rs/data=%h, required 000", {out_rs, out_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push_frame();
        d0 = n_done;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n != int'(RC)) begin n_fail++; $display("FAIL first_frame_latency: got %0d cycles, required %0d", n, RC); end
        n_vec++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b, required 1", busy); end
        @(posedge clk); #1;
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL first_frame_done: got timeout, required frame_done"); end
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %b, required 0", busy); end
        @(posedge clk); #1;
        n_vec++;
        if (n_done - d0 != 1) begin n_fail++; $display("FAIL done_pulses: got %0d, required 1", n_done - d0); end
        n_vec++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL first_frame_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_write();
        bit ok;
        align_tick();
        wr(0, 8'h48, 1'b0);
        wr(1, 8'h49, 1'b0);
        wr(31, 8'h5A, 1'b0);
        push_frame();
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL write_frame_done: got timeout, required frame_done"); end
        n_vec++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL write_frame_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_no_change();
        int  b0 = byte_cnt;
        bit  bad = 1'b0;
        for (int i = 0; i < int'(5 * RC); i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        @(posedge clk); #1;
        n_vec++;
        if (bad) begin n_fail++; $display("FAIL idle_quiet: got activity, required valid=0 busy=0"); end
        n_vec++;
        if (byte_cnt != b0) begin n_fail++; $display("FAIL idle_bytes: got %0d, required 0", byte_cnt - b0); end
    endtask

    task automatic test_stall();
        int  b0;
        int  d0;
        int  n = 0;
        out_ready = 1'b0;
        wr(3, 8'h53, 1'b1);
        push_frame();
        b0 = byte_cnt;
        d0 = n_done;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_start: got valid=%b, required 1", out_valid); end
        for (int k = 0; k < int'(NB); k++) begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (byte_cnt - b0 != int'(NB)) begin n_fail++; $display("FAIL stall_count: got %0d, required %0d", byte_cnt - b0, NB); end
        n_vec++;
        if (n_done - d0 != 1) begin n_fail++; $display("FAIL stall_done: got %0d, required 1", n_done - d0); end
        n_vec++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_midframe_write();
        int  b0;
        bit  ok;
        wr(0, 8'h4D, 1'b0);
        push_frame();
        b0 = byte_cnt;
        wait_bytes(b0 + 20, 100, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL mid_reach_row1: got timeout, required 20 bytes"); end
        wr(2, 8'h78, 1'b0);
        wr(5, 8'h41, 1'b1);
        push_frame();
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL mid_cur_done: got timeout, required frame_done"); end
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL mid_next_done: got timeout, required frame_done"); end
        n_vec++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int  b0;
        bit  ok;
        wr(7, 8'h52, 1'b0);
        push_frame();
        b0 = byte_cnt;
        wait_bytes(b0 + 5, 100, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL rmid_reach_row0: got timeout, required 5 bytes"); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_abort: got valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        push_frame();
        wait_done(100, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL rmid_done: got timeout, required frame_done"); end
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        n_vec++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rmid_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_no_change();
        test_stall();
        test_midframe_write();
        test_reset_mid();
        test_no_change();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
